// File: rtl/isdu_gen2.sv
// Instruction sequencing and decode unit (gen 2) for the SLC-3 datapath.
// Parametrised memory wait counter; control strobes are registered from the next-state decode.
module isdu_gen2 #(
   parameter int MEM_WAIT = 3,
   parameter int WR_WAIT  = 3,
   parameter bit PAUSE_EN = 1'b1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Run,
   input  logic       Continue,
   input  logic [3:0] Opcode,
   input  logic       IR_5,
   input  logic       IR_11,
   input  logic       BEN,
   output logic       LD_MAR,
   output logic       LD_MDR,
   output logic       LD_IR,
   output logic       LD_BEN,
   output logic       LD_CC,
   output logic       LD_REG,
   output logic       LD_PC,
   output logic       LD_LED,
   output logic       GatePC,
   output logic       GateMDR,
   output logic       GateALU,
   output logic       GateMARMUX,
   output logic [1:0] PCMUX,
   output logic       DRMUX,
   output logic       SR1MUX,
   output logic       SR2MUX,
   output logic       ADDR1MUX,
   output logic [1:0] ADDR2MUX,
   output logic [1:0] ALUK,
   output logic       Mem_OE,
   output logic       Mem_WE,
   output logic       Instr_Start
);

   localparam int MAX_WAIT = (MEM_WAIT > WR_WAIT) ? MEM_WAIT : WR_WAIT;
   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] MEM_LOAD = CW'(MEM_WAIT - 1);
   localparam logic [CW-1:0] WR_LOAD  = CW'(WR_WAIT - 1);

   typedef enum logic [4:0] {
      S_HALTED, S_FETCH, S_RD_I, S_IR, S_DECODE,
      S_ADD, S_AND, S_NOT, S_LDR_A, S_STR_A, S_RD_D, S_LDR_WB,
      S_STR_D, S_WR, S_BR, S_BR_T, S_JMP, S_JSR_R7, S_JSR_PC,
      S_LEA, S_PAUSE1, S_PAUSE2
   } state_t;

   typedef struct packed {
      logic       ld_mar;
      logic       ld_mdr;
      logic       ld_ir;
      logic       ld_ben;
      logic       ld_cc;
      logic       ld_reg;
      logic       ld_pc;
      logic       ld_led;
      logic       gate_pc;
      logic       gate_mdr;
      logic       gate_alu;
      logic       gate_marmux;
      logic [1:0] pcmux;
      logic       drmux;
      logic       sr1mux;
      logic       sr2mux;
      logic       addr1mux;
      logic [1:0] addr2mux;
      logic [1:0] aluk;
      logic       mem_oe;
      logic       mem_we;
      logic       instr_start;
   } ctrl_t;

   state_t          state, state_n;
   logic [CW-1:0]   wait_cnt, wait_cnt_n;
   ctrl_t           ctrl;

   // Control word for a state; the wait count only matters for the LD_MDR strobe on the last read cycle.
   function automatic ctrl_t decode(input state_t s, input logic [CW-1:0] c,
                                    input logic ir5, input logic ir11);
      ctrl_t d;
      d = '0;
      case (s)
         S_FETCH:  begin d.gate_pc = 1'b1; d.ld_mar = 1'b1; d.ld_pc = 1'b1; d.instr_start = 1'b1; end
         S_RD_I, S_RD_D: begin d.mem_oe = 1'b1; d.ld_mdr = (c == '0); end
         S_IR:     begin d.gate_mdr = 1'b1; d.ld_ir = 1'b1; end
         S_DECODE: d.ld_ben = 1'b1;
         S_ADD, S_AND: begin
            d.sr1mux = 1'b1; d.sr2mux = ir5;
            d.aluk = (s == S_AND) ? 2'b01 : 2'b00;
            d.gate_alu = 1'b1; d.ld_reg = 1'b1; d.ld_cc = 1'b1;
         end
         S_NOT: begin
            d.sr1mux = 1'b1; d.aluk = 2'b10;
            d.gate_alu = 1'b1; d.ld_reg = 1'b1; d.ld_cc = 1'b1;
         end
         S_LDR_A, S_STR_A: begin
            d.gate_marmux = 1'b1; d.ld_mar = 1'b1;
            d.addr1mux = 1'b1; d.addr2mux = 2'b01; d.sr1mux = 1'b1;
         end
         S_LDR_WB: begin d.gate_mdr = 1'b1; d.ld_reg = 1'b1; d.ld_cc = 1'b1; end
         S_STR_D:  begin d.aluk = 2'b11; d.gate_alu = 1'b1; d.ld_mdr = 1'b1; end
         S_WR:     begin d.mem_we = 1'b1; d.mem_oe = 1'b1; end
         S_BR_T:   begin d.pcmux = 2'b10; d.addr2mux = 2'b10; d.ld_pc = 1'b1; end
         S_JMP:    begin d.sr1mux = 1'b1; d.addr1mux = 1'b1; d.pcmux = 2'b10; d.ld_pc = 1'b1; end
         S_JSR_R7: begin d.gate_pc = 1'b1; d.drmux = 1'b1; d.ld_reg = 1'b1; end
         S_JSR_PC: begin
            d.pcmux = 2'b10; d.ld_pc = 1'b1;
            if (ir11) d.addr2mux = 2'b11;
            else begin d.addr1mux = 1'b1; d.sr1mux = 1'b1; end
         end
         S_LEA: begin
            d.addr2mux = 2'b10; d.gate_marmux = 1'b1;
            d.ld_reg = 1'b1; d.ld_cc = 1'b1;
         end
         S_PAUSE1, S_PAUSE2: d.ld_led = 1'b1;
         default: ;
      endcase
      return d;
   endfunction

   // Next-state and wait-counter logic; the counter is loaded with N-1 on entry to a memory state.
   always_comb begin
      state_n    = state;
      wait_cnt_n = wait_cnt;
      case (state)
         S_HALTED: if (Run) state_n = S_FETCH;
         S_FETCH:  begin state_n = S_RD_I; wait_cnt_n = MEM_LOAD; end
         S_RD_I:   if (wait_cnt == '0) state_n = S_IR; else wait_cnt_n = wait_cnt - 1'b1;
         S_IR:     state_n = S_DECODE;
         S_DECODE: begin
            case (Opcode)
               4'b0001: state_n = S_ADD;
               4'b0101: state_n = S_AND;
               4'b1001: state_n = S_NOT;
               4'b0110: state_n = S_LDR_A;
               4'b0111: state_n = S_STR_A;
               4'b0000: state_n = S_BR;
               4'b1100: state_n = S_JMP;
               4'b0100: state_n = S_JSR_R7;
               4'b1110: state_n = S_LEA;
               4'b1101: state_n = PAUSE_EN ? S_PAUSE1 : S_FETCH;
               default: state_n = S_FETCH;
            endcase
         end
         S_LDR_A:  begin state_n = S_RD_D; wait_cnt_n = MEM_LOAD; end
         S_RD_D:   if (wait_cnt == '0) state_n = S_LDR_WB; else wait_cnt_n = wait_cnt - 1'b1;
         S_STR_A:  state_n = S_STR_D;
         S_STR_D:  begin state_n = S_WR; wait_cnt_n = WR_LOAD; end
         S_WR:     if (wait_cnt == '0) state_n = S_FETCH; else wait_cnt_n = wait_cnt - 1'b1;
         S_BR:     state_n = BEN ? S_BR_T : S_FETCH;
         S_JSR_R7: state_n = S_JSR_PC;
         S_PAUSE1: if (Continue) state_n = S_PAUSE2;
         S_PAUSE2: if (!Continue) state_n = S_FETCH;
         default:  state_n = S_FETCH;
      endcase
   end

   // Outputs are registered from the decode of the next state so they line up with the state register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= S_HALTED;
         wait_cnt <= '0;
         ctrl     <= '0;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_cnt_n;
         ctrl     <= decode(state_n, wait_cnt_n, IR_5, IR_11);
      end
   end

   assign LD_MAR      = ctrl.ld_mar;
   assign LD_MDR      = ctrl.ld_mdr;
   assign LD_IR       = ctrl.ld_ir;
   assign LD_BEN      = ctrl.ld_ben;
   assign LD_CC       = ctrl.ld_cc;
   assign LD_REG      = ctrl.ld_reg;
   assign LD_PC       = ctrl.ld_pc;
   assign LD_LED      = ctrl.ld_led;
   assign GatePC      = ctrl.gate_pc;
   assign GateMDR     = ctrl.gate_mdr;
   assign GateALU     = ctrl.gate_alu;
   assign GateMARMUX  = ctrl.gate_marmux;
   assign PCMUX       = ctrl.pcmux;
   assign DRMUX       = ctrl.drmux;
   assign SR1MUX      = ctrl.sr1mux;
   assign SR2MUX      = ctrl.sr2mux;
   assign ADDR1MUX    = ctrl.addr1mux;
   assign ADDR2MUX    = ctrl.addr2mux;
   assign ALUK        = ctrl.aluk;
   assign Mem_OE      = ctrl.mem_oe;
   assign Mem_WE      = ctrl.mem_we;
   assign Instr_Start = ctrl.instr_start;

endmodule

// File: tb/tb_isdu_gen2.sv
// Directed bench for isdu_gen2: one instance with default waits, one with MEM_WAIT=1/WR_WAIT=5 and PAUSE disabled.
module tb_isdu_gen2;

   typedef struct packed {
      logic       ld_mar;
      logic       ld_mdr;
      logic       ld_ir;
      logic       ld_ben;
      logic       ld_cc;
      logic       ld_reg;
      logic       ld_pc;
      logic       ld_led;
      logic       gate_pc;
      logic       gate_mdr;
      logic       gate_alu;
      logic       gate_marmux;
      logic [1:0] pcmux;
      logic       drmux;
      logic       sr1mux;
      logic       sr2mux;
      logic       addr1mux;
      logic [1:0] addr2mux;
      logic [1:0] aluk;
      logic       mem_oe;
      logic       mem_we;
      logic       instr_start;
   } outs_t;

   logic       Clk, Reset;
   logic       run_a, cont_a, ir5_a, ir11_a, ben_a;
   logic [3:0] op_a;
   logic       run_b, cont_b, ir5_b, ir11_b, ben_b;
   logic [3:0] op_b;

   logic ld_mar_a, ld_mdr_a, ld_ir_a, ld_ben_a, ld_cc_a, ld_reg_a, ld_pc_a, ld_led_a;
   logic gate_pc_a, gate_mdr_a, gate_alu_a, gate_marmux_a, drmux_a, sr1mux_a, sr2mux_a, addr1mux_a;
   logic mem_oe_a, mem_we_a, start_a;
   logic [1:0] pcmux_a, addr2mux_a, aluk_a;
   logic ld_mar_b, ld_mdr_b, ld_ir_b, ld_ben_b, ld_cc_b, ld_reg_b, ld_pc_b, ld_led_b;
   logic gate_pc_b, gate_mdr_b, gate_alu_b, gate_marmux_b, drmux_b, sr1mux_b, sr2mux_b, addr1mux_b;
   logic mem_oe_b, mem_we_b, start_b;
   logic [1:0] pcmux_b, addr2mux_b, aluk_b;

   outs_t outs_a, outs_b;
   int    tests = 0;
   int    failed = 0;

   assign outs_a = {ld_mar_a, ld_mdr_a, ld_ir_a, ld_ben_a, ld_cc_a, ld_reg_a, ld_pc_a, ld_led_a,
                    gate_pc_a, gate_mdr_a, gate_alu_a, gate_marmux_a, pcmux_a, drmux_a, sr1mux_a,
                    sr2mux_a, addr1mux_a, addr2mux_a, aluk_a, mem_oe_a, mem_we_a, start_a};
   assign outs_b = {ld_mar_b, ld_mdr_b, ld_ir_b, ld_ben_b, ld_cc_b, ld_reg_b, ld_pc_b, ld_led_b,
                    gate_pc_b, gate_mdr_b, gate_alu_b, gate_marmux_b, pcmux_b, drmux_b, sr1mux_b,
                    sr2mux_b, addr1mux_b, addr2mux_b, aluk_b, mem_oe_b, mem_we_b, start_b};

   isdu_gen2 dut_a (
      .Clk(Clk), .Reset(Reset), .Run(run_a), .Continue(cont_a), .Opcode(op_a),
      .IR_5(ir5_a), .IR_11(ir11_a), .BEN(ben_a),
      .LD_MAR(ld_mar_a), .LD_MDR(ld_mdr_a), .LD_IR(ld_ir_a), .LD_BEN(ld_ben_a),
      .LD_CC(ld_cc_a), .LD_REG(ld_reg_a), .LD_PC(ld_pc_a), .LD_LED(ld_led_a),
      .GatePC(gate_pc_a), .GateMDR(gate_mdr_a), .GateALU(gate_alu_a), .GateMARMUX(gate_marmux_a),
      .PCMUX(pcmux_a), .DRMUX(drmux_a), .SR1MUX(sr1mux_a), .SR2MUX(sr2mux_a),
      .ADDR1MUX(addr1mux_a), .ADDR2MUX(addr2mux_a), .ALUK(aluk_a),
      .Mem_OE(mem_oe_a), .Mem_WE(mem_we_a), .Instr_Start(start_a)
   );

   isdu_gen2 #(.MEM_WAIT(1), .WR_WAIT(5), .PAUSE_EN(1'b0)) dut_b (
      .Clk(Clk), .Reset(Reset), .Run(run_b), .Continue(cont_b), .Opcode(op_b),
      .IR_5(ir5_b), .IR_11(ir11_b), .BEN(ben_b),
      .LD_MAR(ld_mar_b), .LD_MDR(ld_mdr_b), .LD_IR(ld_ir_b), .LD_BEN(ld_ben_b),
      .LD_CC(ld_cc_b), .LD_REG(ld_reg_b), .LD_PC(ld_pc_b), .LD_LED(ld_led_b),
      .GatePC(gate_pc_b), .GateMDR(gate_mdr_b), .GateALU(gate_alu_b), .GateMARMUX(gate_marmux_b),
      .PCMUX(pcmux_b), .DRMUX(drmux_b), .SR1MUX(sr1mux_b), .SR2MUX(sr2mux_b),
      .ADDR1MUX(addr1mux_b), .ADDR2MUX(addr2mux_b), .ALUK(aluk_b),
      .Mem_OE(mem_oe_b), .Mem_WE(mem_we_b), .Instr_Start(start_b)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Advance one clock and settle 2 time units past the rising edge before sampling.
   task automatic cyc();
      @(posedge Clk);
      #2;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs from one FETCH to the next (bounded) and gathers what the instruction did along the way.
   task automatic measure(input bit use_b, output int len, output int pc_n, output int we_n,
                          output int we_seg, output int led_n, output int r7_n,
                          output logic [1:0] pcm, output logic a1, output logic [1:0] a2);
      outs_t o;
      logic  prev_we;
      pc_n = 0; we_n = 0; we_seg = 0; led_n = 0; r7_n = 0;
      pcm = 2'b00; a1 = 1'b0; a2 = 2'b00; prev_we = 1'b0;
      for (len = 1; len <= 40; len++) begin
         cyc();
         o = use_b ? outs_b : outs_a;
         if (o.instr_start) break;
         if (o.ld_pc) begin pc_n++; pcm = o.pcmux; a1 = o.addr1mux; a2 = o.addr2mux; end
         if (o.mem_we) we_n++;
         if (o.mem_we && !prev_we) we_seg++;
         prev_we = o.mem_we;
         if (o.ld_led) led_n++;
         if (o.gate_pc && o.drmux && o.ld_reg) r7_n++;
      end
   endtask

   task automatic applyStimulus(input bit use_b, input logic [3:0] op, input logic ir5,
                                input logic ir11, input logic ben);
      if (use_b) begin op_b = op; ir5_b = ir5; ir11_b = ir11; ben_b = ben; end
      else begin op_a = op; ir5_a = ir5; ir11_a = ir11; ben_a = ben; end
   endtask

   initial begin
      int len, pc_n, we_n, we_seg, led_n, r7_n;
      logic [1:0] pcm, a2;
      logic a1;

      Reset = 1'b1;
      run_a = 0; cont_a = 0; ir5_a = 0; ir11_a = 0; ben_a = 0; op_a = 4'h0;
      run_b = 0; cont_b = 0; ir5_b = 0; ir11_b = 0; ben_b = 0; op_b = 4'h0;
      repeat (2) cyc();
      checkOutput("reset_outs_a", outs_a, 0);
      checkOutput("reset_outs_b", outs_b, 0);

      // ADD R1,R1,#5 (0x1265); first interrupted by a reset mid-RD_I
      applyStimulus(0, 4'b0001, 1'b1, 1'b0, 1'b0);
      run_a = 1'b1;
      Reset = 1'b0;
      cyc();
      checkOutput("first_fetch", start_a, 1);
      checkOutput("halted_b", outs_b, 0);
      cyc();
      checkOutput("rd1_oe", mem_oe_a, 1);
      cyc();
      checkOutput("rd2_oe", mem_oe_a, 1);
      #1 Reset = 1'b1;
      #1;
      checkOutput("async_reset_outs", outs_a, 0);
      @(negedge Clk);
      Reset = 1'b0;
      cyc();
      checkOutput("fetch_after_reset", start_a, 1);
      checkOutput("fetch_ctrl", {gate_pc_a, ld_mar_a, ld_pc_a, pcmux_a}, 5'b11100);
      for (int k = 2; k <= 4; k++) begin
         cyc();
         checkOutput($sformatf("add_rd%0d_oe_mdr_we", k), {mem_oe_a, ld_mdr_a, mem_we_a},
                     {1'b1, (k == 4), 1'b0});
      end
      cyc();
      checkOutput("add_ir", {gate_mdr_a, ld_ir_a, ld_mdr_a}, 3'b110);
      cyc();
      checkOutput("add_decode", ld_ben_a, 1);
      cyc();
      checkOutput("add_exec", {sr1mux_a, sr2mux_a, drmux_a, aluk_a, gate_alu_a, ld_reg_a, ld_cc_a},
                  8'b11000111);
      cyc();
      checkOutput("add_next_fetch", start_a, 1);

      applyStimulus(0, 4'b1001, 1'b0, 1'b0, 1'b0);
      measure(0, len, pc_n, we_n, we_seg, led_n, r7_n, pcm, a1, a2);
      checkOutput("not_len", len, 7);

      applyStimulus(0, 4'b0000, 1'b0, 1'b0, 1'b0);
      measure(0, len, pc_n, we_n, we_seg, led_n, r7_n, pcm, a1, a2);
      checkOutput("br_nt_len", len, 7);
      checkOutput("br_nt_ldpc", pc_n, 0);

      applyStimulus(0, 4'b0000, 1'b0, 1'b0, 1'b1);
      measure(0, len, pc_n, we_n, we_seg, led_n, r7_n, pcm, a1, a2);
      checkOutput("br_t_len", len, 8);
      checkOutput("br_t_ldpc", pc_n, 1);
      checkOutput("br_t_mux", {pcm, a1, a2}, 5'b10010);

      applyStimulus(0, 4'b0100, 1'b0, 1'b1, 1'b0);
      measure(0, len, pc_n, we_n, we_seg, led_n, r7_n, pcm, a1, a2);
      checkOutput("jsr_len", len, 8);
      checkOutput("jsr_r7", r7_n, 1);
      checkOutput("jsr_mux", {pcm, a1, a2}, 5'b10011);

      applyStimulus(0, 4'b0100, 1'b0, 1'b0, 1'b0);
      measure(0, len, pc_n, we_n, we_seg, led_n, r7_n, pcm, a1, a2);
      checkOutput("jsrr_len", len, 8);
      checkOutput("jsrr_r7", r7_n, 1);
      checkOutput("jsrr_mux", {pcm, a1, a2}, 5'b10100);

      applyStimulus(0, 4'b1100, 1'b0, 1'b0, 1'b0);
      measure(0, len, pc_n, we_n, we_seg, led_n, r7_n, pcm, a1, a2);
      checkOutput("jmp_len", len, 7);
      checkOutput("jmp_mux", {pcm, a1, a2}, 5'b10100);

      applyStimulus(0, 4'b1110, 1'b0, 1'b0, 1'b0);
      measure(0, len, pc_n, we_n, we_seg, led_n, r7_n, pcm, a1, a2);
      checkOutput("lea_len", len, 7);
      checkOutput("lea_ldpc", pc_n, 0);

      applyStimulus(0, 4'b0110, 1'b0, 1'b0, 1'b0);
      measure(0, len, pc_n, we_n, we_seg, led_n, r7_n, pcm, a1, a2);
      checkOutput("ldr_len", len, 11);

      applyStimulus(0, 4'b0111, 1'b0, 1'b0, 1'b0);
      measure(0, len, pc_n, we_n, we_seg, led_n, r7_n, pcm, a1, a2);
      checkOutput("str_len", len, 11);
      checkOutput("str_we", we_n, 3);

      // PAUSE (0xD000) with the Continue handshake
      applyStimulus(0, 4'b1101, 1'b0, 1'b0, 1'b0);
      repeat (6) cyc();
      checkOutput("pause1_led", ld_led_a, 1);
      cyc();
      checkOutput("pause1_hold_led", ld_led_a, 1);
      cont_a = 1'b1;
      cyc();
      checkOutput("pause2_led", ld_led_a, 1);
      cyc();
      checkOutput("pause2_hold", {ld_led_a, start_a}, 2'b10);
      cont_a = 1'b0;
      cyc();
      checkOutput("pause_release", {ld_led_a, start_a}, 2'b01);

      applyStimulus(0, 4'b1000, 1'b0, 1'b0, 1'b0);
      measure(0, len, pc_n, we_n, we_seg, led_n, r7_n, pcm, a1, a2);
      checkOutput("unused_op_len", len, 6);

      // Second instance: MEM_WAIT=1, WR_WAIT=5, PAUSE disabled
      applyStimulus(1, 4'b0110, 1'b0, 1'b0, 1'b0);
      run_b = 1'b1;
      cyc();
      checkOutput("b_first_fetch", start_b, 1);
      measure(1, len, pc_n, we_n, we_seg, led_n, r7_n, pcm, a1, a2);
      checkOutput("b_ldr_len", len, 7);

      applyStimulus(1, 4'b0111, 1'b0, 1'b0, 1'b0);
      measure(1, len, pc_n, we_n, we_seg, led_n, r7_n, pcm, a1, a2);
      checkOutput("b_str_len", len, 11);
      checkOutput("b_str_we", we_n, 5);
      checkOutput("b_str_we_seg", we_seg, 1);

      applyStimulus(1, 4'b1101, 1'b0, 1'b0, 1'b0);
      measure(1, len, pc_n, we_n, we_seg, led_n, r7_n, pcm, a1, a2);
      checkOutput("b_pause_off_len", len, 4);
      checkOutput("b_pause_off_led", led_n, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/isdu_gen2.md
# isdu_gen2

Second-generation instruction sequencing and decode unit for the SLC-3 datapath. It replaces the fixed, unrolled memory wait states with a parametrised wait counter and adds LEA, JSRR (IR_11 mode select) and an optional PAUSE opcode. It drives the same datapath control strobes, muxes and memory enables, and sits between the IR/BEN logic and the datapath/BRAM.

## Interface
- MEM_WAIT, 3: cycles of a memory read (Mem_OE high); ≥1; LD_MDR in the last cycle only
- WR_WAIT, 3: cycles of a memory write (Mem_WE and Mem_OE high); ≥1
- PAUSE_EN, 1: 1 = opcode 1101 enters PauseIR1/PauseIR2; 0 = opcode 1101 is a NOP (returns to fetch)
- Clk in 1: system clock, rising edge
- Reset in 1: asynchronous, active-high; forces Halted
- Run in 1: start; sampled only in Halted
- Continue in 1: pause handshake
- Opcode in 4: IR[15:12]
- IR_5 in 1: ADD/AND immediate select
- IR_11 in 1: JSR (1) / JSRR (0)
- BEN in 1: branch enable
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED out 1: register loads
- GatePC, GateMDR, GateALU, GateMARMUX out 1: bus gates
- PCMUX out 2: 00 PC+1, 01 bus, 10 adder
- DRMUX, SR1MUX, SR2MUX, ADDR1MUX out 1
- ADDR2MUX out 2: 00 zero, 01 off6, 10 off9, 11 off11
- ALUK out 2: 00 ADD, 01 AND, 10 NOT, 11 PASS A
- Mem_OE, Mem_WE out 1: BRAM enables
- Instr_Start out 1: high for the single cycle in FETCH (instruction counter hook)

## Operation
- Moore FSM. All outputs are decoded from the state and the wait counter. Every output not listed for a state is 0.
- States and actions (→ next state):
  - Halted: nothing asserted → FETCH if Run.
  - FETCH: GatePC, LD_MAR, PCMUX=00, LD_PC, Instr_Start → RD_I.
  - RD_I: Mem_OE; LD_MDR on the last count → IR.
  - IR: GateMDR, LD_IR → DECODE.
  - DECODE: LD_BEN → dispatch on Opcode:
    - 0001 ADD; 0101 AND; 1001 NOT
    - 0110 LDR_A; 0111 STR_A
    - 0000 BR; 1100 JMP; 0100 JSR_R7; 1110 LEA
    - 1101 PAUSE1 if PAUSE_EN, else FETCH
    - all others → FETCH
  - ADD/AND: SR1MUX=1, SR2MUX=IR_5, DRMUX=0, ALUK=00/01, GateALU, LD_REG, LD_CC → FETCH.
  - NOT: SR1MUX=1, ALUK=10, GateALU, LD_REG, LD_CC → FETCH.
  - LDR_A and STR_A: GateMARMUX, LD_MAR, ADDR1MUX=1, ADDR2MUX=01, SR1MUX=1. LDR_A → RD_D; STR_A → STR_D.
  - RD_D: same as RD_I → LDR_WB.
  - LDR_WB: GateMDR, DRMUX=0, LD_REG, LD_CC → FETCH.
  - STR_D: SR1MUX=0, ALUK=11, GateALU, LD_MDR → WR.
  - WR: Mem_WE, Mem_OE for WR_WAIT cycles → FETCH.
  - BR: nothing asserted → BR_T if BEN, else FETCH.
  - BR_T: PCMUX=10, ADDR1MUX=0, ADDR2MUX=10, LD_PC → FETCH.
  - JMP: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC → FETCH.
  - JSR_R7: GatePC, DRMUX=1, LD_REG → JSR_PC.
  - JSR_PC: PCMUX=10, LD_PC. IR_11=1: ADDR1MUX=0, ADDR2MUX=11. IR_11=0: ADDR1MUX=1, ADDR2MUX=00, SR1MUX=1. → FETCH.
  - JSRR R7 jumps to the new R7 (the old PC+1). This is defined behaviour.
  - LEA: ADDR1MUX=0, ADDR2MUX=10, GateMARMUX, DRMUX=0, LD_REG, LD_CC → FETCH.
  - PAUSE1: LD_LED; → PAUSE2 when Continue=1.
  - PAUSE2: LD_LED; → FETCH when Continue=0.
- Wait counter, width clog2(max(MEM_WAIT,WR_WAIT)+1):
  - Loaded with N−1 on entry to RD_I, RD_D or WR.
  - Decrements each cycle while in that state.
  - The state exits when the counter reads 0 (the last count).
- IR_11 is ignored by every state except JSR_PC.

## Timing
- Reset (async): State=Halted and counter=0 immediately. All outputs are 0, including Mem_WE mid-write.
- Reset release: the FSM stays in Halted until Run is sampled high on a rising edge.
- Cycles from FETCH to the next FETCH (W=MEM_WAIT, V=WR_WAIT):
  - ADD/AND/NOT/JMP/LEA: W+4
  - BR not taken: W+4
  - BR taken: W+5
  - JSR/JSRR: W+5
  - LDR: 2W+5
  - STR: W+V+5
- Defaults: ADD takes 7 cycles, LDR 11, STR 11.
- Continue held high across PAUSE1→PAUSE2 keeps the FSM in PAUSE2; it takes exactly one FETCH per pause release.
- Run is don't-care outside Halted; the FSM never returns to Halted except on Reset.

## Test plan
- Reset asserted mid-RD_I, then released with Run=1 → all outputs go 0 asynchronously; FETCH (Instr_Start=1) follows on the first edge after release.
- ADD R1,R1,#5 (0x1265), defaults → Mem_OE high for 3 cycles, LD_MDR on the 3rd only; SR2MUX=1, GateALU, LD_REG, LD_CC in cycle 7; Instr_Start again in cycle 8.
- LDR with MEM_WAIT=1 → 7-cycle instruction; STR with WR_WAIT=5 → Mem_WE high for exactly 5 consecutive cycles, then FETCH.
- BR (0x0E02) with BEN=0 → 7 cycles with no LD_PC after FETCH; with BEN=1 → BR_T asserts PCMUX=10, ADDR2MUX=10, LD_PC; 8 cycles total.
- JSR 0x4805 (IR_11=1) → ADDR2MUX=11, ADDR1MUX=0; JSRR 0x4080 (IR_11=0) → ADDR1MUX=1, ADDR2MUX=00; both preceded by GatePC, DRMUX=1, LD_REG.
- 0xD000 with PAUSE_EN=1 → LD_LED high until Continue goes 1 then 0, then FETCH; with PAUSE_EN=0 → FETCH directly after DECODE.
